// File: rtl/johnson_counter_param.sv
// Parametrised Johnson / ring shift counter with enable, load, self-correction,
// combinational phase decode and a registered wrap pulse.
module johnson_counter_param #(
    parameter  int WIDTH = 4,
    localparam int PW    = $clog2(2 * WIDTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             Dir,
    input  logic             Mode,
    input  logic             Load,
    input  logic [WIDTH-1:0] Load_value,
    output logic [WIDTH-1:0] Count_out,
    output logic [PW-1:0]    Phase,
    output logic             Illegal,
    output logic             Wrap
);

    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] inv;
    logic             wrap_next;
    logic             legal;
    logic             thermo;
    logic             inv_thermo;
    logic [PW-1:0]    last_phase;
    int unsigned      ones;

    // Johnson legal states are thermometer codes (0..01..1) or their complements;
    // popcount then gives the phase directly (k, or 2W-k for the inverted half).
    always_comb begin
        ones       = 0;
        Phase      = '0;
        legal      = 1'b0;
        inv        = ~Count_out;
        thermo     = (Count_out & (Count_out + WIDTH'(1))) == '0;
        inv_thermo = (inv & (inv + WIDTH'(1))) == '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            ones += {31'b0, Count_out[i]};
        end
        if (Mode) begin
            legal = (ones == 1);
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (legal && Count_out[i]) begin
                    Phase = PW'(i);
                end
            end
        end else if (thermo) begin
            legal = 1'b1;
            Phase = PW'(ones);
        end else if (inv_thermo) begin
            legal = 1'b1;
            Phase = PW'(2 * WIDTH - ones);
        end
        Illegal = ~legal;
    end

    assign last_phase = Mode ? PW'(WIDTH - 1) : PW'(2 * WIDTH - 1);

    // Wrap is predicted from the current phase: a legal step from the last phase
    // going left lands on 0, and from phase 0 going right lands on the last phase.
    always_comb begin
        count_next = Count_out;
        wrap_next  = 1'b0;
        if (Load) begin
            count_next = Load_value;
        end else if (Enable) begin
            if (!legal) begin
                count_next = Mode ? WIDTH'(1) : '0;
            end else begin
                unique case ({Mode, Dir})
                    2'b00: count_next = {Count_out[WIDTH-2:0], ~Count_out[WIDTH-1]};
                    2'b01: count_next = {~Count_out[0], Count_out[WIDTH-1:1]};
                    2'b10: count_next = {Count_out[WIDTH-2:0], Count_out[WIDTH-1]};
                    2'b11: count_next = {Count_out[0], Count_out[WIDTH-1:1]};
                    default: count_next = Count_out;
                endcase
                wrap_next = Dir ? (Phase == '0) : (Phase == last_phase);
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Count_out <= '0;
            Wrap      <= 1'b0;
        end else begin
            Count_out <= count_next;
            Wrap      <= wrap_next;
        end
    end

endmodule

// File: tb/tb_johnson_counter_param.sv
// Directed self-checking bench for johnson_counter_param at WIDTH=4.
module tb_johnson_counter_param;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       dir;
    logic       mode;
    logic       load;
    logic [3:0] load_value;
    logic [3:0] count_out;
    logic [2:0] phase;
    logic       illegal;
    logic       wrap;

    int n_vec = 0;
    int n_err = 0;

    johnson_counter_param #(.WIDTH(4)) dut (
        .Clock      (clock),
        .Reset      (reset),
        .Enable     (enable),
        .Dir        (dir),
        .Mode       (mode),
        .Load       (load),
        .Load_value (load_value),
        .Count_out  (count_out),
        .Phase      (phase),
        .Illegal    (illegal),
        .Wrap       (wrap)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] c, input logic [2:0] p,
                         input logic il, input logic w);
        n_vec++;
        assert ({count_out, phase, illegal, wrap} === {c, p, il, w}) else begin
            n_err++;
            $error("FAIL %s: got count=%b phase=%0d illegal=%b wrap=%b, want count=%b phase=%0d illegal=%b wrap=%b",
                   tag, count_out, phase, illegal, wrap, c, p, il, w);
        end
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0; load_value = 4'b0000;
        #12;
        check("reset_johnson", 4'b0000, 3'd0, 1'b0, 1'b0);
        mode = 1'b1;
        #1;
        check("reset_ring", 4'b0000, 3'd0, 1'b1, 1'b0);
        mode = 1'b0;
        step();
        reset = 1'b1;

        // Johnson left, full cycle
        enable = 1'b1; dir = 1'b0;
        step(); check("jl1", 4'b0001, 3'd1, 1'b0, 1'b0);
        step(); check("jl2", 4'b0011, 3'd2, 1'b0, 1'b0);
        step(); check("jl3", 4'b0111, 3'd3, 1'b0, 1'b0);
        step(); check("jl4", 4'b1111, 3'd4, 1'b0, 1'b0);
        step(); check("jl5", 4'b1110, 3'd5, 1'b0, 1'b0);
        step(); check("jl6", 4'b1100, 3'd6, 1'b0, 1'b0);
        step(); check("jl7", 4'b1000, 3'd7, 1'b0, 1'b0);
        step(); check("jl0", 4'b0000, 3'd0, 1'b0, 1'b1);

        // Johnson right from 0000
        dir = 1'b1;
        step(); check("jr7", 4'b1000, 3'd7, 1'b0, 1'b1);
        step(); check("jr6", 4'b1100, 3'd6, 1'b0, 1'b0);
        step(); check("jr5", 4'b1110, 3'd5, 1'b0, 1'b0);
        step(); check("jr4", 4'b1111, 3'd4, 1'b0, 1'b0);
        step(); check("jr3", 4'b0111, 3'd3, 1'b0, 1'b0);
        step(); check("jr2", 4'b0011, 3'd2, 1'b0, 1'b0);
        step(); check("jr1", 4'b0001, 3'd1, 1'b0, 1'b0);
        step(); check("jr0", 4'b0000, 3'd0, 1'b0, 1'b0);

        // Ring mode after reset: zero is corrected to 0001
        enable = 1'b0; dir = 1'b0;
        reset = 1'b0;
        #1;
        mode = 1'b1;
        #1;
        check("ring_rst", 4'b0000, 3'd0, 1'b1, 1'b0);
        reset = 1'b1;
        enable = 1'b1;
        step(); check("ring_fix", 4'b0001, 3'd0, 1'b0, 1'b0);
        step(); check("rl1", 4'b0010, 3'd1, 1'b0, 1'b0);
        step(); check("rl2", 4'b0100, 3'd2, 1'b0, 1'b0);
        step(); check("rl3", 4'b1000, 3'd3, 1'b0, 1'b0);
        step(); check("rl0", 4'b0001, 3'd0, 1'b0, 1'b1);
        enable = 1'b0;
        step(); check("ring_hold", 4'b0001, 3'd0, 1'b0, 1'b0);
        enable = 1'b1; dir = 1'b1;
        step(); check("rr3", 4'b1000, 3'd3, 1'b0, 1'b1);
        step(); check("rr2", 4'b0100, 3'd2, 1'b0, 1'b0);

        // Multi-bit value in ring mode is corrected to 0001
        enable = 1'b0; load = 1'b1; load_value = 4'b0110;
        step(); check("ring_ld", 4'b0110, 3'd0, 1'b1, 1'b0);
        load = 1'b0; enable = 1'b1;
        step(); check("ring_fix2", 4'b0001, 3'd0, 1'b0, 1'b0);

        // Johnson illegal load then correction
        mode = 1'b0; dir = 1'b0; enable = 1'b0; load = 1'b1; load_value = 4'b0101;
        step(); check("j_ld_bad", 4'b0101, 3'd0, 1'b1, 1'b0);
        load = 1'b0; enable = 1'b1;
        step(); check("j_fix", 4'b0000, 3'd0, 1'b0, 1'b0);

        // Load beats enable, then hold
        load = 1'b1; load_value = 4'b0011;
        step(); check("ld_win", 4'b0011, 3'd2, 1'b0, 1'b0);
        load = 1'b0; enable = 1'b0;
        step(); check("hold1", 4'b0011, 3'd2, 1'b0, 1'b0);
        step(); check("hold2", 4'b0011, 3'd2, 1'b0, 1'b0);
        step(); check("hold3", 4'b0011, 3'd2, 1'b0, 1'b0);

        // Asynchronous reset mid-count at 1110
        load = 1'b1; load_value = 4'b1110;
        step(); check("ld_1110", 4'b1110, 3'd5, 1'b0, 1'b0);
        load = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("async_rst", 4'b0000, 3'd0, 1'b0, 1'b0);
        #1;
        reset = 1'b1;
        enable = 1'b1;
        step(); check("resume", 4'b0001, 3'd1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
